// File: rtl/tpg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tpg_ctrl_pkg
// Shared definitions for the test-pattern-generator mode controller:
//   - timing field indices (order of the table columns and of wr_idx)
//   - controller FSM state encoding
//   - small elaboration helpers
// -----------------------------------------------------------------------------
package tpg_ctrl_pkg;

    // Number of timing fields per mode entry
    localparam int N_FIELDS = 10;

    // Field indices, as used on wr_idx
    localparam logic [3:0] F_HS_START   = 4'd0;
    localparam logic [3:0] F_HS_END     = 4'd1;
    localparam logic [3:0] F_HACT_START = 4'd2;
    localparam logic [3:0] F_HACT_END   = 4'd3;
    localparam logic [3:0] F_H_END      = 4'd4;
    localparam logic [3:0] F_VS_START   = 4'd5;
    localparam logic [3:0] F_VS_END     = 4'd6;
    localparam logic [3:0] F_VACT_START = 4'd7;
    localparam logic [3:0] F_VACT_END   = 4'd8;
    localparam logic [3:0] F_V_END      = 4'd9;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_HOLD    = 2'd3
    } state_e;

    // Index width for n entries, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    // Fields 5..8 are vertical and only V_BITS wide; tV_END is H_BITS wide
    function automatic logic is_v_field(input logic [3:0] idx);
        return (idx >= F_VS_START) && (idx <= F_VACT_END);
    endfunction

endpackage

// File: rtl/tpg_mode_table.sv
// -----------------------------------------------------------------------------
// tpg_mode_table
// Register file of N_MODES timing entries, N_FIELDS fields each.
// Ports:
//   clk, rst_n            clock, async active-low reset (clears every field)
//   wr_en/wr_mode/wr_idx/wr_data
//                         single write port; wr_idx > 9 is ignored, vertical
//                         fields keep only the low V_BITS, others low H_BITS
//   rd_mode / rd_fields   combinational read of a whole entry
//   chk_mode / chk_ok     combinational "tH_END and tV_END both nonzero" check
// The read ports see the stored value, so a write in the same cycle as a
// read returns the old contents.
// -----------------------------------------------------------------------------
module tpg_mode_table
    import tpg_ctrl_pkg::*;
#(
    parameter int H_BITS  = 12,
    parameter int V_BITS  = 12,
    parameter int N_MODES = 4,
    parameter int M_BITS  = 2,
    localparam int D_BITS = (H_BITS > V_BITS) ? H_BITS : V_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [M_BITS-1:0] wr_mode,
    input  logic [3:0]        wr_idx,
    input  logic [D_BITS-1:0] wr_data,
    input  logic [M_BITS-1:0] rd_mode,
    output logic [D_BITS-1:0] rd_fields [N_FIELDS],
    input  logic [M_BITS-1:0] chk_mode,
    output logic              chk_ok
);

    logic [D_BITS-1:0] tab_q [N_MODES][N_FIELDS];
    logic [D_BITS-1:0] tab_d [N_MODES][N_FIELDS];

    // Trim a write value to the width of the field it lands in
    function automatic logic [D_BITS-1:0] field_mask(input logic [3:0] idx,
                                                     input logic [D_BITS-1:0] d);
        logic [D_BITS-1:0] m;
        if (is_v_field(idx)) begin
            m = D_BITS'({V_BITS{1'b1}});
        end else begin
            m = D_BITS'({H_BITS{1'b1}});
        end
        return d & m;
    endfunction

    // Next table contents: one field updated on a legal write
    always_comb begin
        tab_d = tab_q;
        if (wr_en && (int'(wr_idx) < N_FIELDS) && (int'(wr_mode) < N_MODES)) begin
            tab_d[wr_mode][wr_idx] = field_mask(wr_idx, wr_data);
        end else begin
            tab_d = tab_q;
        end
    end

    // Whole-entry read for the timing load
    always_comb begin
        for (int f = 0; f < N_FIELDS; f++) begin
            rd_fields[f] = '0;
        end
        if (int'(rd_mode) < N_MODES) begin
            rd_fields = tab_q[rd_mode];
        end else begin
            for (int f = 0; f < N_FIELDS; f++) begin
                rd_fields[f] = '0;
            end
        end
    end

    // Validity check of the entry being offered on the select port
    always_comb begin
        chk_ok = 1'b0;
        if (int'(chk_mode) < N_MODES) begin
            chk_ok = (tab_q[chk_mode][F_H_END] != '0) && (tab_q[chk_mode][F_V_END] != '0);
        end else begin
            chk_ok = 1'b0;
        end
    end

    // Table storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < N_MODES; m++) begin
                for (int f = 0; f < N_FIELDS; f++) begin
                    tab_q[m][f] <= '0;
                end
            end
        end else begin
            tab_q <= tab_d;
        end
    end

endmodule

// File: rtl/tpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tpg_mode_ctrl
// Mode controller for the video test pattern generator. Holds a table of
// timing sets and drives the generator from one active copy. A select from
// RUN waits for the next rising edge of vs_q, then loads the new timings and
// holds the generator in reset for HOLD_CYC cycles, so each frame uses a
// single consistent timing set.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   wr_en/wr_mode/wr_idx/wr_data  table write port
//   sel_valid/sel_ready/sel_mode  mode-select handshake
//   sel_err                    one-cycle pulse on a rejected select (or watchdog)
//   vs_q                       vertical sync from the generator
//   tpg_rst_n                  synchronous active-low reset to the generator
//   busy                       high while waiting for a frame edge or holding
//   active_mode                mode currently applied
//   tHS_START .. tV_END        timing outputs to the generator (all registered)
//
// Optional feature: define TPG_MODE_CTRL_TIMEOUT_EN to add a TO_BITS watchdog
// that forces the switch when no frame edge arrives while waiting.
// -----------------------------------------------------------------------------
module tpg_mode_ctrl
    import tpg_ctrl_pkg::*;
#(
    parameter int H_BITS   = 12,
    parameter int V_BITS   = 12,
    parameter int N_MODES  = 4,
    parameter int HOLD_CYC = 4,
    parameter int TO_BITS  = 24,
    localparam int M_BITS  = clog2_min1(N_MODES),
    localparam int D_BITS  = (H_BITS > V_BITS) ? H_BITS : V_BITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [M_BITS-1:0] wr_mode,
    input  logic [3:0]        wr_idx,
    input  logic [D_BITS-1:0] wr_data,
    input  logic              sel_valid,
    output logic              sel_ready,
    input  logic [M_BITS-1:0] sel_mode,
    output logic              sel_err,
    input  logic              vs_q,
    output logic              tpg_rst_n,
    output logic              busy,
    output logic [M_BITS-1:0] active_mode,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [H_BITS-1:0] tV_END
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 32'sd1);

    state_e            state_q, state_d;
    logic              vs_d_q;          // vs_q delayed one cycle, for edge detect
    logic [7:0]        hold_cnt_q, hold_cnt_d;
    logic [M_BITS-1:0] pend_q, pend_d;  // mode waiting for the frame edge
    logic              sel_err_q, sel_err_d;
    logic              sel_ready_q, sel_ready_d;
    logic              tpg_rst_n_q, tpg_rst_n_d;
    logic              busy_q, busy_d;
    logic [M_BITS-1:0] active_mode_q, active_mode_d;
    logic [D_BITS-1:0] tim_q [N_FIELDS];
    logic [D_BITS-1:0] tim_d [N_FIELDS];

    logic              sel_fire_s;
    logic              sel_ok_s;
    logic              vs_rise_s;
    logic              load_s;
    logic              to_expire_s;
    logic [M_BITS-1:0] rd_mode_s;
    logic [D_BITS-1:0] rd_fields_s [N_FIELDS];

    assign sel_fire_s = sel_valid & sel_ready_q;
    assign vs_rise_s  = vs_q & ~vs_d_q;
    // While waiting, the load address is the pending mode, not the live port
    assign rd_mode_s  = (state_q == ST_WAIT_VS) ? pend_q : sel_mode;

    tpg_mode_table #(
        .H_BITS  (H_BITS),
        .V_BITS  (V_BITS),
        .N_MODES (N_MODES),
        .M_BITS  (M_BITS)
    ) u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_mode   (wr_mode),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .rd_mode   (rd_mode_s),
        .rd_fields (rd_fields_s),
        .chk_mode  (sel_mode),
        .chk_ok    (sel_ok_s)
    );

`ifdef TPG_MODE_CTRL_TIMEOUT_EN
    logic [TO_BITS-1:0] to_cnt_q, to_cnt_d;
    logic [TO_BITS-1:0] to_inc_s;

    assign to_inc_s    = to_cnt_q + TO_BITS'(1'b1);
    // Fire on the cycle the count would reach all-ones
    assign to_expire_s = (state_q == ST_WAIT_VS) && (to_inc_s == '1);

    // Watchdog next value: clear on WAIT_VS entry, count while waiting
    always_comb begin
        to_cnt_d = to_cnt_q;
        if ((state_q != ST_WAIT_VS) && (state_d == ST_WAIT_VS)) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT_VS) begin
            to_cnt_d = to_inc_s;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign to_expire_s = 1'b0;
    // TO_BITS only sizes the watchdog; this empty block keeps it referenced.
    if (TO_BITS > 0) begin : g_no_watchdog
    end
`endif

    // FSM next state, hold counter and select handling
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        hold_cnt_d = hold_cnt_q;
        sel_err_d  = 1'b0;
        load_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_fire_s) begin
                    if (sel_ok_s) begin
                        state_d = ST_HOLD;
                        load_s  = 1'b1;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sel_fire_s) begin
                    if (sel_ok_s) begin
                        state_d = ST_WAIT_VS;
                        pend_d  = sel_mode;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT_VS: begin
                if (vs_rise_s) begin
                    state_d = ST_HOLD;
                    load_s  = 1'b1;
                end else if (to_expire_s) begin
                    state_d   = ST_HOLD;
                    load_s    = 1'b1;
                    sel_err_d = 1'b1;
                end else begin
                    state_d = ST_WAIT_VS;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            hold_cnt_d = HOLD_LOAD;
        end else begin
            hold_cnt_d = hold_cnt_d;
        end
    end

    // Registered outputs derived from the next state and the load strobe
    always_comb begin
        sel_ready_d   = (state_d == ST_IDLE) || (state_d == ST_RUN);
        tpg_rst_n_d   = (state_d == ST_RUN) || (state_d == ST_WAIT_VS);
        busy_d        = (state_d == ST_WAIT_VS) || (state_d == ST_HOLD);
        active_mode_d = active_mode_q;
        tim_d         = tim_q;
        if (load_s) begin
            active_mode_d = rd_mode_s;
            tim_d         = rd_fields_s;
        end else begin
            active_mode_d = active_mode_q;
            tim_d         = tim_q;
        end
    end

    // Controller state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vs_d_q        <= 1'b0;
            hold_cnt_q    <= 8'd0;
            pend_q        <= '0;
            sel_err_q     <= 1'b0;
            sel_ready_q   <= 1'b1;
            tpg_rst_n_q   <= 1'b0;
            busy_q        <= 1'b0;
            active_mode_q <= '0;
            for (int f = 0; f < N_FIELDS; f++) begin
                tim_q[f] <= '0;
            end
        end else begin
            state_q       <= state_d;
            vs_d_q        <= vs_q;
            hold_cnt_q    <= hold_cnt_d;
            pend_q        <= pend_d;
            sel_err_q     <= sel_err_d;
            sel_ready_q   <= sel_ready_d;
            tpg_rst_n_q   <= tpg_rst_n_d;
            busy_q        <= busy_d;
            active_mode_q <= active_mode_d;
            tim_q         <= tim_d;
        end
    end

    assign sel_ready   = sel_ready_q;
    assign sel_err     = sel_err_q;
    assign tpg_rst_n   = tpg_rst_n_q;
    assign busy        = busy_q;
    assign active_mode = active_mode_q;

    assign tHS_START   = tim_q[F_HS_START][H_BITS-1:0];
    assign tHS_END     = tim_q[F_HS_END][H_BITS-1:0];
    assign tHACT_START = tim_q[F_HACT_START][H_BITS-1:0];
    assign tHACT_END   = tim_q[F_HACT_END][H_BITS-1:0];
    assign tH_END      = tim_q[F_H_END][H_BITS-1:0];
    assign tVS_START   = tim_q[F_VS_START][V_BITS-1:0];
    assign tVS_END     = tim_q[F_VS_END][V_BITS-1:0];
    assign tVACT_START = tim_q[F_VACT_START][V_BITS-1:0];
    assign tVACT_END   = tim_q[F_VACT_END][V_BITS-1:0];
    assign tV_END      = tim_q[F_V_END][H_BITS-1:0];

endmodule

// File: tb/tb_tpg_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tpg_mode_ctrl
// Directed bench for tpg_mode_ctrl. Expected timing sets come from a local
// table model and are queued when a select is driven; a monitor pops and
// compares them each time a HOLD window ends, also checking its length.
// -----------------------------------------------------------------------------
module tb_tpg_mode_ctrl;
    import tpg_ctrl_pkg::*;

    localparam int HC = 4;

    typedef struct packed {
        logic [1:0]        mode;
        logic [9:0][11:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_mode = 2'd0;
    logic [3:0]  wr_idx = 4'd0;
    logic [11:0] wr_data = 12'd0;
    logic        sel_valid = 1'b0;
    logic        sel_ready;
    logic [1:0]  sel_mode = 2'd0;
    logic        sel_err;
    logic        vs_q = 1'b0;
    logic        tpg_rst_n;
    logic        busy;
    logic [1:0]  active_mode;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic [119:0] out_vec;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    logic [11:0] mdl [4][10];

    always #5 clk = ~clk;

    tpg_mode_ctrl #(
        .H_BITS(12), .V_BITS(12), .N_MODES(4), .HOLD_CYC(HC), .TO_BITS(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_idx(wr_idx), .wr_data(wr_data),
        .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_mode(sel_mode),
        .sel_err(sel_err), .vs_q(vs_q), .tpg_rst_n(tpg_rst_n), .busy(busy),
        .active_mode(active_mode),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END), .tVS_START(tVS_START),
        .tVS_END(tVS_END), .tVACT_START(tVACT_START), .tVACT_END(tVACT_END),
        .tV_END(tV_END)
    );

    assign out_vec = {tV_END, tVACT_END, tVACT_START, tVS_END, tVS_START,
                      tH_END, tHACT_END, tHACT_START, tHS_END, tHS_START};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [119:0] vec_of(input logic [1:0] m);
        logic [119:0] v;
        for (int i = 0; i < 10; i++) v[i*12 +: 12] = mdl[m][i];
        return v;
    endfunction

    task automatic wr(input logic [1:0] m, input logic [3:0] idx, input logic [11:0] d);
        wr_en = 1'b1; wr_mode = m; wr_idx = idx; wr_data = d;
        tick();
        wr_en = 1'b0;
        if (idx < 4'd10) mdl[m][idx] = d;
    endtask

    task automatic push_exp(input logic [1:0] m);
        exp_t e;
        e.mode = m;
        e.f = vec_of(m);
        sb_q.push_back(e);
    endtask

    task automatic sel(input logic [1:0] m);
        sel_valid = 1'b1; sel_mode = m;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (!(tpg_rst_n && !busy) && n < 50) begin
            tick();
            n++;
        end
        check(tag, 128'(n < 50), 128'd1);
    endtask

    // Scoreboard monitor: a HOLD window ends when tpg_rst_n rises after it
    int   hold_len = 0;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_len  = 0;
            prev_hold = 1'b0;
        end else begin
            if (busy && !tpg_rst_n) begin
                hold_len++;
            end else if (prev_hold && tpg_rst_n) begin
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("hold_len", 128'(hold_len), 128'(HC));
                    check("sb_mode", 128'(active_mode), 128'(e.mode));
                    check("sb_timing", 128'(out_vec), 128'(e.f));
                end
                hold_len = 0;
            end
            prev_hold = busy && !tpg_rst_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0]  m1 [10];
        logic [11:0]  m2 [10];
        logic [119:0] old2;
        int n;
        m1 = '{12'd10, 12'd20, 12'd30, 12'd90, 12'd100, 12'd2, 12'd4, 12'd6, 12'd46, 12'd50};
        m2 = '{12'd11, 12'd21, 12'd31, 12'd91, 12'd120, 12'd3, 12'd5, 12'd7, 12'd57, 12'd60};
        for (int m = 0; m < 4; m++) for (int i = 0; i < 10; i++) mdl[m][i] = 12'd0;

        // 1. Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("rst_tpg_rst_n", 128'(tpg_rst_n), 128'd0);
        check("rst_sel_ready", 128'(sel_ready), 128'd1);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_sel_err", 128'(sel_err), 128'd0);
        check("rst_active_mode", 128'(active_mode), 128'd0);
        check("rst_timing", 128'(out_vec), 128'd0);

        // 2. Program modes, then load mode 1 from IDLE
        for (int i = 0; i < 10; i++) wr(2'd1, 4'(i), m1[i]);
        for (int i = 0; i < 10; i++) wr(2'd2, 4'(i), m2[i]);
        wr(2'd3, F_H_END, 12'd80);
        wr(2'd1, 4'd12, 12'hFFF);
        check("wr_no_effect", 128'(out_vec), 128'd0);
        push_exp(2'd1);
        sel(2'd1);
        check("idle_hold_busy", 128'(busy), 128'd1);
        check("idle_hold_rst", 128'(tpg_rst_n), 128'd0);
        check("idle_hold_ready", 128'(sel_ready), 128'd0);
        check("idle_load_timing", 128'(out_vec), 128'(vec_of(2'd1)));
        check("idle_load_mode", 128'(active_mode), 128'd1);
        wait_run("wait_run_1");
        check("run_ready", 128'(sel_ready), 128'd1);
        tick();

        // 3. Switch to mode 2 at a frame edge, with a colliding write
        push_exp(2'd2);
        old2 = vec_of(2'd2);
        sel(2'd2);
        check("wait_busy", 128'(busy), 128'd1);
        check("wait_rst_hi", 128'(tpg_rst_n), 128'd1);
        for (int k = 0; k < 3; k++) begin
            check("wait_ready_lo", 128'(sel_ready), 128'd0);
            check("wait_timing_old", 128'(out_vec), 128'(vec_of(2'd1)));
            tick();
        end
        vs_q = 1'b1;
        wr(2'd2, F_HS_START, 12'd999);
        check("edge_timing_new", 128'(out_vec), 128'(old2));
        check("edge_mode", 128'(active_mode), 128'd2);
        check("edge_rst_lo", 128'(tpg_rst_n), 128'd0);
        check("edge_ready_lo", 128'(sel_ready), 128'd0);
        tick();
        vs_q = 1'b0;
        wait_run("wait_run_2");
        tick();

        // 4. Invalid entry (mode 3 has tV_END == 0)
        sel(2'd3);
        check("err_pulse", 128'(sel_err), 128'd1);
        check("err_busy", 128'(busy), 128'd0);
        check("err_mode", 128'(active_mode), 128'd2);
        check("err_timing", 128'(out_vec), 128'(old2));
        tick();
        check("err_one_cycle", 128'(sel_err), 128'd0);

        // 5. Write into active mode, then reselect it
        wr(2'd2, F_H_END, 12'd200);
        tick();
        check("active_wr_hidden", 128'(out_vec), 128'(old2));
        push_exp(2'd2);
        sel(2'd2);
        tick();
        check("reselect_wait_old", 128'(out_vec), 128'(old2));
        vs_q = 1'b1;
        tick();
        check("reselect_th_end", 128'(tH_END), 128'd200);
        vs_q = 1'b0;
        wait_run("wait_run_3");
        tick();

        // 6. Reset in the second HOLD cycle
        push_exp(2'd1);
        sel(2'd1);
        vs_q = 1'b1;
        tick();
        vs_q = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_tpg_rst_n", 128'(tpg_rst_n), 128'd0);
        check("mid_rst_ready", 128'(sel_ready), 128'd1);
        check("mid_rst_busy", 128'(busy), 128'd0);
        check("mid_rst_mode", 128'(active_mode), 128'd0);
        check("mid_rst_timing", 128'(out_vec), 128'd0);
        sb_q.delete();
        for (int m = 0; m < 4; m++) for (int i = 0; i < 10; i++) mdl[m][i] = 12'd0;
        tick();
        rst_n = 1'b1;
        tick();
        sel(2'd1);
        check("cleared_table_err", 128'(sel_err), 128'd1);
        check("cleared_table_busy", 128'(busy), 128'd0);
        tick();

`ifdef TPG_MODE_CTRL_TIMEOUT_EN
        // Watchdog: no frame edge, forced switch after 15 waiting cycles
        wr(2'd1, F_H_END, 12'd100);
        wr(2'd1, F_V_END, 12'd50);
        push_exp(2'd1);
        sel(2'd1);
        wait_run("wait_run_to0");
        tick();
        push_exp(2'd1);
        sel(2'd1);
        n = 0;
        while (busy && tpg_rst_n && n < 40) begin
            n++;
            tick();
        end
        check("to_wait_cycles", 128'(n), 128'd15);
        check("to_sel_err", 128'(sel_err), 128'd1);
        check("to_hold", 128'(tpg_rst_n), 128'd0);
        wait_run("wait_run_to1");
        tick();
`endif

        tick();
        check("sb_drained", 128'(sb_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tpg_mode_ctrl.md
# tpg_mode_ctrl

Mode controller for the video test pattern generator (`tpg`). It holds a programmable table of `N_MODES` timing sets and drives the generator's ten timing inputs from one active copy. On a mode-select handshake it waits for the next frame boundary, then swaps the timings. It holds the generator in reset for a short window so that every frame is produced with one consistent timing set.

## Interface
- `H_BITS`, 12, horizontal timing width; must equal the generator's `H_BITS`
- `V_BITS`, 12, vertical timing width; must equal the generator's `V_BITS`
- `N_MODES`, 4, table entries; `M_BITS = $clog2(N_MODES)`, minimum 1
- `HOLD_CYC`, 4, cycles `tpg_rst_n` is held low per switch; range 1..255
- `TO_BITS`, 24, watchdog counter width; used only with `TPG_MODE_CTRL_TIMEOUT_EN`
- `clk` in 1: single clock, shared with the generator
- `rst_n` in 1: reset, asynchronous, active-low
- `wr_en` in 1: table write strobe
- `wr_mode` in M_BITS: table entry to write
- `wr_idx` in 4: field index; 0 `tHS_START`, 1 `tHS_END`, 2 `tHACT_START`, 3 `tHACT_END`, 4 `tH_END`, 5 `tVS_START`, 6 `tVS_END`, 7 `tVACT_START`, 8 `tVACT_END`, 9 `tV_END`
- `wr_data` in D_BITS = max(H_BITS,V_BITS): field value; V fields take the low `V_BITS`; `tV_END` takes the low `H_BITS`
- `sel_valid` in 1 / `sel_ready` out 1 / `sel_mode` in M_BITS: mode-select handshake
- `sel_err` out 1: one-cycle pulse when a select is rejected
- `vs_q` in 1: vertical sync fed back from the generator
- `tpg_rst_n` out 1: synchronous reset to the generator, active-low
- `busy` out 1: high in WAIT_VS and HOLD
- `active_mode` out M_BITS: currently applied mode
- Timing outputs, ten of them, named exactly as the generator inputs (`tHS_START` … `tV_END`); widths match the generator, with `tV_END` being `H_BITS`

## Operation
- **Table storage and reset**
  - Table is `N_MODES` x 10 registers.
  - On reset, all table fields, all timing outputs and `active_mode` clear to 0.
  - `wr_idx` values above 9 are ignored.
  - Writes never change the timing outputs directly; the new values take effect only when that mode is next selected.
- **FSM states:** IDLE, RUN, WAIT_VS, HOLD. Reset state is IDLE.
  - IDLE: `tpg_rst_n`=0, `sel_ready`=1.
  - RUN: `tpg_rst_n`=1, `sel_ready`=1.
  - WAIT_VS: `tpg_rst_n`=1, `sel_ready`=0. Waits for a frame edge.
  - HOLD: `tpg_rst_n`=0, `sel_ready`=0. Counts `HOLD_CYC` cycles, then goes to RUN.
- **Select handshake**
  - A select is accepted when `sel_valid & sel_ready`.
  - **Rejected:** if the selected entry has `tH_END`==0 or `tV_END`==0, pulse `sel_err` for one cycle and leave the state unchanged. The handshake still completes.
  - **Accepted from IDLE:** go to HOLD.
  - **Accepted from RUN:** go to WAIT_VS. Reselecting the active mode is legal and restarts the generator.
- **Frame edge:** rising edge of `vs_q`, i.e. `vs_q & ~vs_d`, where `vs_d` is `vs_q` registered. The `vs_d` register resets to 0.
- **Entering HOLD**
  - Copy the selected entry into the timing outputs and update `active_mode`.
  - Load the hold counter with `HOLD_CYC-1`.
- **Write/load collision:** a table write in the same cycle as the HOLD-entry load is not seen by the load; the old value is loaded.
- **Reset mid-operation:** at any state, immediately go to IDLE with all outputs at their reset values. Any pending select is dropped.

## Timing
- Reset values:
  - `sel_ready`=1, `tpg_rst_n`=0.
  - `busy`, `sel_err` = 0.
  - `active_mode` and all timing outputs = 0.
- Select accepted at edge N in RUN: WAIT_VS from N+1.
- Frame edge detected at edge E: HOLD from E+1, with the timing outputs updated at E+1.
- `tpg_rst_n` is low for exactly `HOLD_CYC` cycles, E+1 .. E+`HOLD_CYC`, and high from E+`HOLD_CYC`+1. `sel_ready` returns to 1 on the same edge.
- Select accepted at edge N in IDLE: HOLD from N+1. No frame wait.
- `sel_err` is asserted the cycle after the rejected handshake.
- Timing outputs are stable for the whole period `tpg_rst_n` is high.

## Configuration
- `TPG_MODE_CTRL_TIMEOUT_EN` defined:
  - A `TO_BITS` counter clears on entry to WAIT_VS and increments each cycle.
  - When it reaches all-ones without a frame edge, force the transition to HOLD, as if the edge had occurred, and pulse `sel_err` for one cycle.
- Undefined: WAIT_VS waits indefinitely, and no counter logic is present.

## Structure
- Package `tpg_ctrl_pkg` holds:
  - the field index constants 0..9 and `N_FIELDS`=10;
  - the FSM state encoding, 2 bits, IDLE=0, RUN=1, WAIT_VS=2, HOLD=3.
- Sub-module `tpg_mode_table` holds the register file:
  - one write port, one combinational read port for a whole entry;
  - a separate read of the `tH_END`/`tV_END` nonzero check for the `sel_mode` entry.

## Test plan
1. **Reset state:** release reset → `tpg_rst_n`=0, `sel_ready`=1, all timing outputs 0, `busy`=0.
2. **Load from IDLE:** write mode 1 (`tH_END`=100, `tV_END`=50, other fields nonzero), then select 1 from IDLE → HOLD on the next edge; timing outputs match mode 1; `tpg_rst_n` low for exactly 4 cycles; `active_mode`=1.
3. **Switch at frame edge:** in RUN with mode 1 running, select 2 mid-frame → outputs unchanged until the `vs_q` rising edge; update 1 cycle after it; `tpg_rst_n` low for 4 cycles; `sel_ready`=0 throughout.
4. **Invalid entry:** select mode 3 with `tV_END`=0 → `sel_err` pulses 1 cycle; state, `active_mode` and outputs unchanged.
5. **Write to active mode:** write `tH_END`=200 into active mode 2 → outputs keep the old value; reselect 2 → 200 applied after the next frame edge.
6. **Reset during HOLD:** assert `rst_n` in cycle 2 of HOLD → immediate IDLE and zero outputs. With `TPG_MODE_CTRL_TIMEOUT_EN` and `TO_BITS`=4, `vs_q` held at 0: a select forces HOLD after 15 cycles, with a `sel_err` pulse.
